sha256_digest_padder: RTL

//  Downstream of the 256-bit block memory in the double-SHA256 datapath. Takes the stored

---
 rtl/sha256_pkg.sv | 22 ++
 rtl/sha256_digest_padder.sv | 75 +++++++
 2 files changed

// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the double-SHA256 datapath.
// Also holds a helper that picks one 32-bit word out of a 256-bit digest.
package sha256_pkg;

  localparam logic [31:0] SHA256_PAD_WORD     = 32'h8000_0000;
  localparam int unsigned SHA256_BLOCK_WORDS  = 16;
  localparam int unsigned SHA256_DIGEST_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } pad_state_e;

  // Word 0 is the most significant 32 bits of the digest (H0).
  function automatic logic [31:0] digest_word(input logic [255:0] blk, input logic [2:0] i);
    logic [255:0] shifted;
    shifted = blk << {i, 5'b0};
    return shifted[255:224];
  endfunction

endpackage

// File: rtl/sha256_digest_padder.sv
// Streams a captured 256-bit first-pass digest as the padded 16-word message block
// for the second SHA256 pass, under a valid/ready handshake.
module sha256_digest_padder
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_BITS = 256
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [255:0] block_in,
  output logic         busy,
  output logic         word_valid,
  input  logic         word_ready,
  output logic [31:0]  word_out,
  output logic [3:0]   word_idx,
  output logic         last,
  output logic         done
);

  localparam logic [31:0] LenWord  = 32'(LEN_BITS);
  localparam logic [3:0]  LastIdx  = 4'(SHA256_BLOCK_WORDS - 1);
  localparam logic [3:0]  PadIdx   = 4'(SHA256_DIGEST_WORDS);

  pad_state_e   state_q;
  logic [255:0] capture_q;
  logic [3:0]   idx_q;
  logic [31:0]  word_sel;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      capture_q <= '0;
      idx_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Snapshot the digest so upstream memory is free to be rewritten.
          if (start) begin
            capture_q <= block_in;
            idx_q     <= '0;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (word_ready) begin
            idx_q <= idx_q + 4'd1;
            if (idx_q == LastIdx) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    word_sel = '0;
    if (idx_q < PadIdx) begin
      word_sel = digest_word(capture_q, idx_q[2:0]);
    end else if (idx_q == PadIdx) begin
      word_sel = SHA256_PAD_WORD;
    end else if (idx_q == LastIdx) begin
      word_sel = LenWord;
    end
  end

  assign busy       = (state_q != IDLE);
  assign word_valid = (state_q == SEND);
  assign done       = (state_q == DONE);
  assign last       = word_valid && (idx_q == LastIdx);
  assign word_idx   = idx_q;
  assign word_out   = word_valid ? word_sel : 32'h0;

endmodule
